// File: rtl/rotate_unit.sv
`default_nettype none
// ============================================================================
// Module   : rotate_unit
// Purpose  : Iterative barrel rotate/shift unit. One operation per start
//            pulse; the shift amount is resolved one binary stage per cycle
//            (1, 2, 4, ... positions), then result, carry and zero are
//            registered together with a one-cycle done pulse. A global
//            enable freezes every register (reset still takes priority).
// Ports    : clk, rst (sync, active-high), enable, start,
//            op (0 ROTL, 1 ROTR, 2 LSL, 3 LSR, 4 ASR, 5-7 as LSL),
//            operand[WIDTH], amount[AMT_W]  -> busy, done, result[WIDTH],
//            carry, zero
// Revision : 1.0 - initial release
// ============================================================================
module rotate_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_RUN      = 1'b1;
    localparam logic [AMT_W-1:0] c_AMT_ZERO = '0;
    localparam logic [AMT_W-1:0] c_AMT_ONE  = AMT_W'(1);
    localparam logic [AMT_W-1:0] c_LAST     = AMT_W'(AMT_W - 1);
    localparam logic [AMT_W:0]   c_ONE      = (AMT_W + 1)'(1);
    localparam logic [AMT_W:0]   c_WIDTH    = (AMT_W + 1)'(WIDTH);

    localparam logic [2:0] c_OP_ROTL = 3'd0;
    localparam logic [2:0] c_OP_ROTR = 3'd1;
    localparam logic [2:0] c_OP_LSR  = 3'd3;
    localparam logic [2:0] c_OP_ASR  = 3'd4;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [AMT_W-1:0] r_k;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_orig;
    logic [AMT_W-1:0] r_amount;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_done;

    logic [AMT_W:0]   w_s;        // positions moved by this stage (0 or 2^k)
    logic [AMT_W:0]   w_rs;       // complementary distance for wrap-around
    logic [WIDTH-1:0] w_stage;    // working value after this stage
    logic [AMT_W-1:0] w_lsl_idx;  // WIDTH-n, modulo WIDTH
    logic [AMT_W-1:0] w_lsr_idx;  // n-1
    logic             w_carry;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else if (enable) begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start)          w_next_state = c_RUN;
            c_RUN:   if (r_k == c_LAST)  w_next_state = c_IDLE;
            default:                     w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (r_state == c_RUN);
        done   = r_done;
        result = r_result;
        carry  = r_carry;
        zero   = r_zero;
    end

    // ------------------------------------------------------------------
    // One shift stage. A zero stage distance makes the wrap term shift by
    // WIDTH, which yields zero, so rotates pass the value through intact.
    // ------------------------------------------------------------------
    always_comb begin
        w_s  = r_amount[r_k] ? (c_ONE << r_k) : '0;
        w_rs = c_WIDTH - w_s;
        case (r_op)
            c_OP_ROTL: w_stage = (r_work << w_s) | (r_work >> w_rs);
            c_OP_ROTR: w_stage = (r_work >> w_s) | (r_work << w_rs);
            c_OP_LSR:  w_stage = r_work >> w_s;
            c_OP_ASR:  w_stage = $signed(r_work) >>> w_s;
            default:   w_stage = r_work << w_s;   // LSL and reserved codes
        endcase
    end

    // Carry is taken from the original operand for shifts and from the
    // final value for rotates; only meaningful on the last stage.
    always_comb begin
        w_lsl_idx = c_AMT_ZERO - r_amount;
        w_lsr_idx = r_amount - c_AMT_ONE;
        w_carry   = 1'b0;
        if (r_amount != c_AMT_ZERO) begin
            case (r_op)
                c_OP_ROTL: w_carry = w_stage[0];
                c_OP_ROTR: w_carry = w_stage[WIDTH-1];
                c_OP_LSR,
                c_OP_ASR:  w_carry = r_orig[w_lsr_idx];
                default:   w_carry = r_orig[w_lsl_idx];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= '0;
            r_op     <= '0;
            r_work   <= '0;
            r_orig   <= '0;
            r_amount <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else if (enable) begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_work   <= operand;
                        r_orig   <= operand;
                        r_amount <= amount;
                        r_k      <= '0;
                    end
                end
                c_RUN: begin
                    r_work <= w_stage;
                    r_k    <= r_k + c_AMT_ONE;
                    if (r_k == c_LAST) begin
                        r_k      <= '0;
                        r_result <= w_stage;
                        r_carry  <= w_carry;
                        r_zero   <= (w_stage == '0);
                        r_done   <= 1'b1;
                    end
                end
                default: r_k <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotate_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotate_unit
// Purpose  : Self-checking bench for rotate_unit (WIDTH=32) with an
//            arithmetic reference model of rotate/shift and carry rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand;
    logic [4:0]  amount;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry;
    logic        zero;

    int errors = 0;
    int checks = 0;

    rotate_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .start   (start),
        .op      (op),
        .operand (operand),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    // Reference: result and carry straight from the operation definitions.
    function automatic void model(input logic [2:0] m_op, input logic [31:0] o,
                                  input int n, output logic [31:0] r,
                                  output logic c);
        logic signed [31:0] so;
        so = o;
        case (m_op)
            3'd0:    r = (n == 0) ? o : ((o << n) | (o >> (32 - n)));
            3'd1:    r = (n == 0) ? o : ((o >> n) | (o << (32 - n)));
            3'd3:    r = o >> n;
            3'd4:    r = so >>> n;
            default: r = o << n;
        endcase
        if (n == 0)            c = 1'b0;
        else if (m_op == 3'd0) c = r[0];
        else if (m_op == 3'd1) c = r[31];
        else if (m_op == 3'd3 || m_op == 3'd4) c = o[n-1];
        else                   c = o[32-n];
    endfunction

    // Issue one operation and follow it to done. Edges are counted from the
    // accepting edge (edge 1). Enable is dropped after edges
    // stall_at..stall_at+stall_len-1; poke_at>0 pulses a foreign start then.
    task automatic run_op(input string name, input logic [2:0] t_op,
                          input logic [31:0] t_operand, input int t_amt,
                          input int stall_at, input int stall_len,
                          input int poke_at);
        logic [31:0] exp_r;
        logic        exp_c;
        int          lat;
        model(t_op, t_operand, t_amt, exp_r, exp_c);
        @(negedge clk);
        op = t_op; operand = t_operand; amount = 5'(t_amt);
        start = 1'b1; enable = 1'b1;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (stall_len == 0 && e <= 5) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy/done edge %0d: busy=%b done=%b want busy=1 done=0",
                             name, e, busy, done);
                end
            end
            if (done === 1'b1) begin
                lat = e;
                break;
            end
            @(negedge clk);
            start = 1'b0;
            enable = !(e >= stall_at && e < stall_at + stall_len);
            if (poke_at > 0 && e == poke_at) begin
                start = 1'b1; op = 3'd1; operand = 32'hDEAD_BEEF; amount = 5'd7;
            end
        end
        checks++;
        if (lat != 6 + stall_len) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, 6 + stall_len);
        end
        checks++;
        if (result !== exp_r || carry !== exp_c || zero !== (exp_r == 0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: result=%h carry=%b zero=%b busy=%b want %h %b %b 0",
                     name, result, carry, zero, busy, exp_r, exp_c, exp_r == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; start = 1'b0; op = '0; operand = '0; amount = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done, carry, zero} !== 4'b0 || result !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b result=%h carry=%b zero=%b want all 0",
                         i, busy, done, result, carry, zero);
            end
        end
    endtask

    task automatic test_directed();
        run_op("rotl",  3'd0, 32'h8000_0001, 4,  0, 0, 0);
        run_op("lsl",   3'd2, 32'hF000_0000, 4,  0, 0, 0);
        run_op("lsr",   3'd3, 32'h0000_0003, 1,  0, 0, 0);
        run_op("asr",   3'd4, 32'h8000_0000, 31, 0, 0, 0);
        run_op("rotr",  3'd1, 32'h0000_0001, 1,  0, 0, 0);
        run_op("amt0",  3'd1, 32'h1234_5678, 0,  0, 0, 0);
        run_op("rsvd7", 3'd7, 32'h0000_0003, 31, 0, 0, 0);
    endtask

    task automatic test_done_clears();
        @(negedge clk);
        start = 1'b0; enable = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL done_clear: done=%b result=%h want 0 80000000", done, result);
        end
    endtask

    task automatic test_stall();
        run_op("stall", 3'd2, 32'h0000_0001, 31, 2, 3, 1);
        test_done_clears();
        // done held through a disabled edge, then cleared on the next one
        run_op("stall_done", 3'd2, 32'h0000_0001, 31, 0, 0, 0);
        @(negedge clk);
        start = 1'b0; enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: done=%b want 1", done);
        end
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_release: done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        // run_op starts in the done cycle of the previous op
        run_op("b2b_a", 3'd0, 32'hA5A5_0F0F, 13, 0, 0, 0);
        run_op("b2b_b", 3'd4, 32'h9000_0000, 3,  0, 0, 0);
        run_op("b2b_c", 3'd3, 32'hFFFF_FFFF, 31, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        @(negedge clk);
        op = 3'd0; operand = 32'hFFFF_0000; amount = 5'd9; start = 1'b1; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, carry, zero} !== 4'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h carry=%b zero=%b want all 0",
                     busy, done, result, carry, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_discard: busy/done seen %0d cycles want 0", seen_done);
        end
        run_op("after_reset", 3'd1, 32'h0000_00F0, 8, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] r_op;
            int         r_amt;
            r_op  = 3'($urandom_range(0, 7));
            r_amt = (i < 4) ? ((i % 2 == 0) ? 31 : 1) : int'($urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), r_op, $urandom, r_amt, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
